z88_ram_arbiter: RTL
====================

Name: z88_ram_arbiter

Overview:
Shares the single slot-0 internal SRAM port between two requesters. The CPU path is the Blink-decoded Z80 access with irce_n. The LCD path is the screen-fetch engine, which issues read bursts for the display file.
- Sequences the asynchronous SRAM strobes (ce_n/oe_n/we_n) with programmable access timing.
- Arbitrates by fixed CPU priority, with an anti-starvation override for the LCD.
- Sits between the Blink glue and the ram_* pins of the z88 top level.

Parameters:
ACCESS_CYCLES, 2, clk cycles that ce_n/oe_n stay low for a read (must be >= 1)
WE_CYCLES, 2, clk cycles of the we_n low pulse for a write (must be >= 1)
STARVE_MAX, 8, consecutive CPU grants made while lcd_req is high before the LCD is forced ahead of the CPU

Ports:
clk  in  1  master clock (z88_mck)
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_a  in  19  CPU byte address
cpu_wd  in  8  CPU write data
cpu_rd  out  8  CPU read data; valid in the cpu_ack cycle, held until the next CPU read
cpu_ack  out  1  one-cycle completion pulse
lcd_req  in  1  LCD fetch request; read-only; level, held until lcd_ack
lcd_a  in  19  LCD byte address
lcd_rd  out  8  LCD read data; valid in the lcd_ack cycle, held until the next LCD read
lcd_ack  out  1  one-cycle completion pulse
ram_a  out  19  SRAM address
ram_di  out  8  data driven to the SRAM
ram_do  in  8  data returned from the SRAM
ram_ce_n  out  1  SRAM chip enable
ram_oe_n  out  1  SRAM output enable
ram_we_n  out  1  SRAM write enable

Behaviour:
- Reset (asynchronous, immediate):
  - ram_ce_n, ram_oe_n, ram_we_n = 1.
  - ram_a, ram_di, cpu_rd, lcd_rd = 0.
  - cpu_ack, lcd_ack = 0.
  - State = IDLE, starvation counter = 0.
  - A reset asserted mid-operation drops all strobes in the same instant. The aborted transaction gets no ack.
- All outputs are registered.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE arbitration, on the clock edge:
  - If cpu_req and not (lcd_req and starve == STARVE_MAX): grant the CPU.
  - Else if lcd_req: grant the LCD.
  - Else stay in IDLE.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on every CPU grant made while lcd_req = 1.
  - Clears on every LCD grant.
  - A CPU grant made while lcd_req = 0 leaves it unchanged.
- At grant, latch: address, write data, direction, and owner.
  - ram_a and ram_di come from the latched values.
  - Later changes on cpu_a, cpu_wd or lcd_a have no effect on an access in progress.
- Read path:
  - IDLE -> READ, with ce_n = 0 and oe_n = 0 for exactly ACCESS_CYCLES cycles.
  - ram_do is sampled at the final READ edge into the owner's rd register.
  - READ -> DONE.
- Write path (CPU only):
  - IDLE -> WR_SETUP for 1 cycle: ce_n = 0, we_n = 1, address and data valid.
  - -> WR_PULSE for WE_CYCLES cycles: we_n = 0.
  - -> WR_HOLD for 1 cycle: we_n = 1, ce_n = 0, address and data still held.
  - -> DONE.
  - oe_n stays 1 throughout every write.
- DONE:
  - All strobes are high (bus turnaround).
  - The owner's ack is high for exactly this one cycle.
  - DONE -> IDLE unconditionally.
- Latency, counted from the edge where IDLE samples the request:
  - Read: ack is high in cycle ACCESS_CYCLES+1 (cycle 3 at default).
  - Write: ack is high in cycle WE_CYCLES+3 (cycle 5 at default).
- Minimum spacing between grants: ack cycle + 1 IDLE cycle. A requester holding req high across its ack starts a new transaction, re-arbitrated in IDLE.
- Request deasserted mid-access: the access still completes and the ack still pulses.
- ram_we_n and ram_oe_n are never both low.
- ram_ce_n is low only in READ, WR_SETUP, WR_PULSE and WR_HOLD.
- Address passes through unmodified. No wrap or translation happens in this block.

Decomposition:
- z88_pkg holds:
  - the arb_state_t enum (six states);
  - the owner_t enum (OWN_CPU, OWN_LCD);
  - the default timing constants Z88_RAM_ACCESS_CYCLES = 2, Z88_RAM_WE_CYCLES = 2, Z88_LCD_STARVE_MAX = 8.
- Single module. The shared timing counter and the starvation counter are internal; no sub-module is warranted.

Test Plan:
- Reset mid-read: assert reset while ram_ce_n = 0 -> strobes high in the same cycle, no ack, state IDLE after release.
- CPU read: cpu_req = 1, cpu_we = 0, cpu_a = 0x12345, ram_do = 0xA5 -> ram_a = 0x12345, ce_n/oe_n low cycles 1-2; in cycle 3 cpu_ack = 1 and cpu_rd = 0xA5, strobes high.
- CPU write: cpu_a = 0x00100, cpu_wd = 0x3C -> setup 1 cycle, we_n low cycles 2-3, hold cycle 4, cpu_ack in cycle 5; oe_n = 1 throughout and ram_di = 0x3C from cycle 1 to cycle 4.
- Simultaneous requests: cpu_req and lcd_req both held high continuously -> 8 CPU grants, then 1 LCD grant, then 8 CPU grants again; lcd_ack count = 1 per 9 grants.
- LCD burst alone: lcd_req held, lcd_a stepping 0x7F000..0x7F00F on each ack -> 16 lcd_acks spaced 4 cycles apart, each lcd_rd equal to the model memory contents.
- Request dropped mid-access: cpu_req low in cycle 1 of a read -> the access completes and cpu_ack still pulses in cycle 3.

Source files
------------

// File: rtl/z88_pkg.sv
// Shared types and default timing constants for the Z88 slot-0 RAM arbiter.
package z88_pkg;

   // Arbiter sequencing states; the write path is CPU-only.
   typedef enum logic [2:0] {
      IDLE,
      READ,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } arb_state_t;

   // Which requester owns the transaction in flight.
   typedef enum logic {
      OWN_CPU,
      OWN_LCD
   } owner_t;

   localparam int Z88_RAM_ACCESS_CYCLES = 2;
   localparam int Z88_RAM_WE_CYCLES     = 2;
   localparam int Z88_LCD_STARVE_MAX    = 8;

   // Larger of two integers, used to size the shared timing counter.
   function automatic int z88_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/z88_ram_arbiter.sv
// Slot-0 internal SRAM arbiter: shares one asynchronous SRAM port between the
// Blink-decoded CPU path and the LCD screen-fetch engine. The CPU has fixed
// priority, except that a long run of CPU grants while the LCD waits forces
// one LCD grant ahead of the CPU. All outputs are registered.
import z88_pkg::*;

module z88_ram_arbiter #(
   parameter int ACCESS_CYCLES = Z88_RAM_ACCESS_CYCLES,
   parameter int WE_CYCLES     = Z88_RAM_WE_CYCLES,
   parameter int STARVE_MAX    = Z88_LCD_STARVE_MAX
) (
   input  logic        clk,
   input  logic        reset,
   // CPU requester
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [18:0] cpu_a,
   input  logic [7:0]  cpu_wd,
   output logic [7:0]  cpu_rd,
   output logic        cpu_ack,
   // LCD requester (read-only)
   input  logic        lcd_req,
   input  logic [18:0] lcd_a,
   output logic [7:0]  lcd_rd,
   output logic        lcd_ack,
   // SRAM pins
   output logic [18:0] ram_a,
   output logic [7:0]  ram_di,
   input  logic [7:0]  ram_do,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   // One counter times both the read strobe and the write pulse.
   localparam int CNT_MAX = z88_max(z88_max(ACCESS_CYCLES, WE_CYCLES), 1);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int STV_W   = $clog2(z88_max(STARVE_MAX, 1) + 1);

   localparam logic [CNT_W-1:0] CNT_RD_LOAD = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_WE_LOAD = CNT_W'(WE_CYCLES - 1);
   localparam logic [STV_W-1:0] STV_SAT     = STV_W'(STARVE_MAX);

   arb_state_t        r_state;
   owner_t            r_own;
   logic [CNT_W-1:0]  r_cnt;
   logic [STV_W-1:0]  r_starve;

   logic              w_starved;
   logic              w_grant_cpu;
   logic              w_grant_lcd;

   // IDLE arbitration: CPU first unless the LCD has waited out STARVE_MAX grants.
   always_comb begin
      w_starved   = lcd_req && (r_starve == STV_SAT);
      w_grant_cpu = cpu_req && !w_starved;
      w_grant_lcd = lcd_req && !w_grant_cpu;
   end

   // Transaction sequencer: grant, strobe timing, data capture and ack pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_own    <= OWN_CPU;
         r_cnt    <= '0;
         r_starve <= '0;
         ram_a    <= '0;
         ram_di   <= '0;
         ram_ce_n <= 1'b1;
         ram_oe_n <= 1'b1;
         ram_we_n <= 1'b1;
         cpu_rd   <= '0;
         lcd_rd   <= '0;
         cpu_ack  <= 1'b0;
         lcd_ack  <= 1'b0;
      end else begin
         // Acks are single-cycle; only the transition into DONE raises one.
         cpu_ack <= 1'b0;
         lcd_ack <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_grant_cpu) begin
                  r_own  <= OWN_CPU;
                  ram_a  <= cpu_a;
                  ram_di <= cpu_wd;
                  // Only grants that actually made the LCD wait count toward starvation.
                  if (lcd_req && (r_starve != STV_SAT)) begin
                     r_starve <= r_starve + 1'b1;
                  end
                  if (cpu_we) begin
                     r_state  <= WR_SETUP;
                     ram_ce_n <= 1'b0;
                  end else begin
                     r_state  <= READ;
                     r_cnt    <= CNT_RD_LOAD;
                     ram_ce_n <= 1'b0;
                     ram_oe_n <= 1'b0;
                  end
               end else if (w_grant_lcd) begin
                  r_own    <= OWN_LCD;
                  ram_a    <= lcd_a;
                  r_starve <= '0;
                  r_state  <= READ;
                  r_cnt    <= CNT_RD_LOAD;
                  ram_ce_n <= 1'b0;
                  ram_oe_n <= 1'b0;
               end
            end

            READ: begin
               if (r_cnt == '0) begin
                  // Final READ edge: capture SRAM data and release the bus.
                  ram_ce_n <= 1'b1;
                  ram_oe_n <= 1'b1;
                  r_state  <= DONE;
                  if (r_own == OWN_CPU) begin
                     cpu_rd  <= ram_do;
                     cpu_ack <= 1'b1;
                  end else begin
                     lcd_rd  <= ram_do;
                     lcd_ack <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            WR_SETUP: begin
               ram_we_n <= 1'b0;
               r_cnt    <= CNT_WE_LOAD;
               r_state  <= WR_PULSE;
            end

            WR_PULSE: begin
               if (r_cnt == '0) begin
                  ram_we_n <= 1'b1;
                  r_state  <= WR_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            WR_HOLD: begin
               // Address and data stay valid through the hold cycle; only the LCD never writes.
               ram_ce_n <= 1'b1;
               cpu_ack  <= 1'b1;
               r_state  <= DONE;
            end

            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state  <= IDLE;
               ram_ce_n <= 1'b1;
               ram_oe_n <= 1'b1;
               ram_we_n <= 1'b1;
            end
         endcase
      end
   end

endmodule
